// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: access-size encodings,
// bridge FSM states and the alignment rule.
package dmem_bridge_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_ACCESS,
    DM_WAIT,
    DM_ACK
  } dm_state_t;

  // A request never reaches the SRAM if its size is illegal or its
  // address is not a multiple of the access size.
  function automatic logic size_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr != 2'b00);
      SZ_HALF: bad = addr[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_bridge_lane.sv
// Byte-lane steering: byte enables, write-data replication, read-data
// alignment with zero extension, and misalignment detection.
module dmem_lane
  import dmem_bridge_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_al,
  output logic        misalign
);

  // Lane selection for the current access size and low address bits.
  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_al  = '0;
    misalign  = size_misaligned(size, addr);
    case (size)
      SZ_WORD: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_al  = rdata;
      end
      SZ_HALF: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_al  = {16'h0000, (addr[1] ? rdata[31:16] : rdata[15:0])};
      end
      SZ_BYTE: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        case (addr)
          2'd0:    rdata_al = {24'h000000, rdata[7:0]};
          2'd1:    rdata_al = {24'h000000, rdata[15:8]};
          2'd2:    rdata_al = {24'h000000, rdata[23:16]};
          default: rdata_al = {24'h000000, rdata[31:24]};
        endcase
      end
      default: begin
        be        = '0;
        wdata_rep = '0;
        rdata_al  = '0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the core data port and a synchronous
// byte-enabled 32-bit SRAM, with configurable wait states.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MREQ,
  input  logic              WRITE,
  input  logic [1:0]        SIZE,
  input  logic [31:0]       DAD,
  input  logic [31:0]       ddt_wr,
  output logic [31:0]       ddt_rd,
  output logic              ACKD_n,
  output logic              err,
  output logic              sram_cs_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

  dm_state_t         state, state_nxt;
  logic [1:0]        req_addr;
  logic [1:0]        req_size;
  logic              req_write;
  logic [CNT_W-1:0]  wait_cnt;

  logic [1:0]        lane_addr;
  logic [1:0]        lane_size;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              lane_mis;

  logic              cs_n_d, we_n_d, ack_n_d, err_d;
  logic [3:0]        be_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d, rd_d;

  logic              dad_unused;
  assign dad_unused = ^DAD[31:ADDR_W+2];

  // In IDLE the lanes see the live request so the ACCESS-cycle strobes can
  // be registered on the sampling edge; afterwards they see the latched one.
  always_comb begin
    lane_addr = req_addr;
    lane_size = req_size;
    if (state == DM_IDLE) begin
      lane_addr = DAD[1:0];
      lane_size = SIZE;
    end
  end

  dmem_lane u_lane (
    .addr      (lane_addr),
    .size      (lane_size),
    .wdata     (ddt_wr),
    .rdata     (sram_rdata),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_al  (lane_rdata),
    .misalign  (lane_mis)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DM_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      DM_IDLE:   if (MREQ) state_nxt = lane_mis ? DM_ACK : DM_ACCESS;
      DM_ACCESS: state_nxt = DM_WAIT;
      DM_WAIT:   if (wait_cnt == '0) state_nxt = DM_ACK;
      DM_ACK:    state_nxt = DM_IDLE;
      default:   state_nxt = DM_IDLE;
    endcase
  end

  // Next values of the registered outputs, one cycle ahead of the state
  // they belong to.
  always_comb begin
    cs_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_d    = '0;
    addr_d  = sram_addr;
    wdata_d = sram_wdata;
    ack_n_d = 1'b1;
    err_d   = 1'b0;
    rd_d    = ddt_rd;
    case (state)
      DM_IDLE: begin
        if (MREQ) begin
          if (lane_mis) begin
            ack_n_d = 1'b0;
            err_d   = 1'b1;
            rd_d    = '0;
          end else begin
            cs_n_d  = 1'b0;
            we_n_d  = ~WRITE;
            be_d    = lane_be;
            addr_d  = DAD[ADDR_W+1:2];
            wdata_d = lane_wdata;
          end
        end
      end
      DM_WAIT: begin
        if (wait_cnt == '0) begin
          ack_n_d = 1'b0;
          if (!req_write) rd_d = lane_rdata;
        end
      end
      default: ;
    endcase
  end

  // Output registers; reset releases the SRAM strobes immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_cs_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      ACKD_n     <= 1'b1;
      err        <= 1'b0;
      ddt_rd     <= '0;
    end else begin
      sram_cs_n  <= cs_n_d;
      sram_we_n  <= we_n_d;
      sram_be    <= be_d;
      sram_addr  <= addr_d;
      sram_wdata <= wdata_d;
      ACKD_n     <= ack_n_d;
      err        <= err_d;
      ddt_rd     <= rd_d;
    end
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr  <= '0;
      req_size  <= SZ_WORD;
      req_write <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (state == DM_IDLE && MREQ) begin
        req_addr  <= DAD[1:0];
        req_size  <= SIZE;
        req_write <= WRITE;
      end
      if (state == DM_ACCESS)
        wait_cnt <= WS_INIT;
      else if (state == DM_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: two instances (0 and 3 wait states), each with its
// own SRAM model, checked against a byte-array reference memory.
module tb_dmem_bridge;

  logic        clk;
  logic        rst        [2];
  logic        mreq       [2];
  logic        write      [2];
  logic [1:0]  size       [2];
  logic [31:0] dad        [2];
  logic [31:0] ddt_wr     [2];
  logic [31:0] ddt_rd     [2];
  logic        ack_n      [2];
  logic        err        [2];
  logic        cs_n       [2];
  logic        we_n       [2];
  logic [3:0]  be         [2];
  logic [7:0]  saddr      [2];
  logic [31:0] sram_wdata [2];
  logic [31:0] sram_rdata [2];

  logic [31:0] smem [2][256];
  logic        smem_init = 1'b0;
  logic [7:0]  gm   [2][1024];
  logic [31:0] mrd  [2];
  int          checks = 0;
  int          errors = 0;

  dmem_bridge #(.WAIT_STATES(0), .ADDR_W(8)) dut0 (
    .clk(clk), .rst(rst[0]), .MREQ(mreq[0]), .WRITE(write[0]), .SIZE(size[0]),
    .DAD(dad[0]), .ddt_wr(ddt_wr[0]), .ddt_rd(ddt_rd[0]), .ACKD_n(ack_n[0]),
    .err(err[0]), .sram_cs_n(cs_n[0]), .sram_we_n(we_n[0]), .sram_be(be[0]),
    .sram_addr(saddr[0]), .sram_wdata(sram_wdata[0]), .sram_rdata(sram_rdata[0]));

  dmem_bridge #(.WAIT_STATES(3), .ADDR_W(8)) dut1 (
    .clk(clk), .rst(rst[1]), .MREQ(mreq[1]), .WRITE(write[1]), .SIZE(size[1]),
    .DAD(dad[1]), .ddt_wr(ddt_wr[1]), .ddt_rd(ddt_rd[1]), .ACKD_n(ack_n[1]),
    .err(err[1]), .sram_cs_n(cs_n[1]), .sram_we_n(we_n[1]), .sram_be(be[1]),
    .sram_addr(saddr[1]), .sram_wdata(sram_wdata[1]), .sram_rdata(sram_rdata[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int d, input int w);
    return 32'h9E3779B9 * 32'(w + 1) + 32'(d) * 32'h01234567;
  endfunction

  // Synchronous SRAM models: read data valid the cycle after a cs_n-low edge.
  always @(posedge clk) begin
    if (!smem_init) begin
      for (int g = 0; g < 2; g++)
        for (int w = 0; w < 256; w++) smem[g][w] <= init_word(g, w);
      smem_init <= 1'b1;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (!cs_n[g]) begin
          if (!we_n[g]) begin
            for (int i = 0; i < 4; i++)
              if (be[g][i]) smem[g][saddr[g]][8*i +: 8] <= sram_wdata[g][8*i +: 8];
          end else begin
            sram_rdata[g] <= smem[g][saddr[g]];
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One complete request on bridge d, checked against the reference memory.
  task automatic xact(input int d, input logic wr, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int ack_cyc, output logic [31:0] o_rd,
                      output logic o_err, output logic [3:0] o_be,
                      output logic [31:0] o_wd);
    int ws, nb, off, cs_cnt;
    logic mis;
    logic [3:0] ebe;
    logic [31:0] ewd, erd;
    ws  = (d == 0) ? 0 : 3;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b00 && a[1:0] != 2'b00);
    nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    ebe = 4'(((1 << nb) - 1) << a[1:0]);
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = 8'(wd >> (8 * (i % nb)));
    off = int'(a[9:0]);
    erd = '0;
    if (!mis) begin
      if (wr) erd = mrd[d];
      else for (int i = 0; i < nb; i++) erd[8*i +: 8] = gm[d][off + i];
    end
    write[d] = wr; size[d] = sz; dad[d] = a; ddt_wr[d] = wd; mreq[d] = 1'b1;
    @(posedge clk);
    ack_cyc = 0; cs_cnt = 0; o_rd = '0; o_err = 1'b0; o_be = '0; o_wd = '0;
    for (int n = 1; n <= 40 && ack_cyc == 0; n++) begin
      @(negedge clk);
      if (n == 1) mreq[d] = 1'b0;
      if (!cs_n[d]) begin
        cs_cnt++;
        chk("cs_cycle", n, 1);
        chk("we_n", we_n[d], !wr);
        chk("be", be[d], ebe);
        chk("sram_addr", saddr[d], a[9:2]);
        if (wr) chk("sram_wdata", sram_wdata[d], ewd);
        o_be = be[d]; o_wd = sram_wdata[d];
      end
      if (!mis && n >= 2 && n <= 2 + ws)
        chk("wait_strobes", {cs_n[d], we_n[d], be[d]}, 6'b110000);
      if (!ack_n[d]) begin
        ack_cyc = n; o_rd = ddt_rd[d]; o_err = err[d];
      end
    end
    chk("ack_cycle", ack_cyc, mis ? 1 : 3 + ws);
    chk("cs_count", cs_cnt, mis ? 0 : 1);
    chk("err", o_err, mis);
    chk("ddt_rd", o_rd, erd);
    @(negedge clk);
    chk("ack_width", ack_n[d], 1'b1);
    chk("rd_hold", ddt_rd[d], erd);
    mrd[d] = erd;
    if (wr && !mis)
      for (int i = 0; i < nb; i++) gm[d][off + i] = 8'(wd >> (8 * i));
  endtask

  // Word loads with MREQ held high: ACKs must be 4+WAIT_STATES cycles apart.
  task automatic spacing(input int d, input logic [31:0] a);
    int ws, last, cnt, cyc;
    logic [31:0] erd;
    ws = (d == 0) ? 0 : 3;
    for (int i = 0; i < 4; i++) erd[8*i +: 8] = gm[d][int'(a[9:0]) + i];
    write[d] = 1'b0; size[d] = 2'b00; dad[d] = a; mreq[d] = 1'b1;
    last = -1; cnt = 0; cyc = 0;
    while (cnt < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!ack_n[d]) begin
        if (last >= 0) chk("ack_spacing", cyc - last, 4 + ws);
        chk("b2b_rd", ddt_rd[d], erd);
        last = cyc;
        cnt++;
        if (cnt == 3) mreq[d] = 1'b0;
      end
    end
    chk("b2b_count", cnt, 3);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_quiet", {cs_n[d], ack_n[d]}, 2'b11);
    mrd[d] = erd;
  endtask

  task automatic check_reset_values(input int d);
    chk("rst_cs_n", cs_n[d], 1'b1);
    chk("rst_we_n", we_n[d], 1'b1);
    chk("rst_be", be[d], 4'h0);
    chk("rst_addr", saddr[d], 8'h00);
    chk("rst_wdata", sram_wdata[d], 32'h0);
    chk("rst_ack_n", ack_n[d], 1'b1);
    chk("rst_err", err[d], 1'b0);
    chk("rst_ddt_rd", ddt_rd[d], 32'h0);
  endtask

  // Start a load, assert reset in cycle `at` of the access, check the abort.
  task automatic abort(input int d, input int at, input logic [31:0] a);
    write[d] = 1'b0; size[d] = 2'b00; dad[d] = a; mreq[d] = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= at; n++) begin
      @(negedge clk);
      if (n == 1) mreq[d] = 1'b0;
    end
    chk("abort_pre_cs_n", cs_n[d], (at == 1) ? 1'b0 : 1'b1);
    rst[d] = 1'b0;
    #1;
    check_reset_values(d);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_ack", {ack_n[d], cs_n[d]}, 2'b11);
    end
    rst[d] = 1'b1;
    mrd[d] = '0;
  endtask

  typedef struct {
    int          d;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    int          ack;
    logic        err;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] swd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int ac;
    logic [31:0] ord, owd, ra;
    logic oerr;
    logic [3:0] obe;
    logic [1:0] rsz;
    int rnb;

    tbl[0]  = '{0, 1'b1, 2'b00, 32'h0000_0100, 32'hDEADBEEF, 3, 1'b0, 32'h0000_0000, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{0, 1'b1, 2'b00, 32'h0000_0100, 32'h11223344, 3, 1'b0, 32'h0000_0000, 4'hF, 32'h11223344};
    tbl[2]  = '{0, 1'b0, 2'b10, 32'h0000_0102, 32'h0,        3, 1'b0, 32'h0000_0022, 4'h4, 32'h0};
    tbl[3]  = '{0, 1'b0, 2'b01, 32'h0000_0102, 32'h0,        3, 1'b0, 32'h0000_1122, 4'hC, 32'h0};
    tbl[4]  = '{0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,        3, 1'b0, 32'h1122_3344, 4'hF, 32'h0};
    tbl[5]  = '{0, 1'b1, 2'b01, 32'h0000_0102, 32'hFFFFBEEF, 3, 1'b0, 32'h1122_3344, 4'hC, 32'hBEEFBEEF};
    tbl[6]  = '{0, 1'b1, 2'b10, 32'h0000_0103, 32'h123456A5, 3, 1'b0, 32'h1122_3344, 4'h8, 32'hA5A5A5A5};
    tbl[7]  = '{0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,        3, 1'b0, 32'hA5EF_3344, 4'hF, 32'h0};
    tbl[8]  = '{0, 1'b0, 2'b00, 32'h0000_0101, 32'h0,        1, 1'b1, 32'h0000_0000, 4'h0, 32'h0};
    tbl[9]  = '{0, 1'b0, 2'b01, 32'h0000_0103, 32'h0,        1, 1'b1, 32'h0000_0000, 4'h0, 32'h0};
    tbl[10] = '{0, 1'b0, 2'b11, 32'h0000_0100, 32'h0,        1, 1'b1, 32'h0000_0000, 4'h0, 32'h0};
    tbl[11] = '{0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,        3, 1'b0, 32'hA5EF_3344, 4'hF, 32'h0};
    tbl[12] = '{0, 1'b1, 2'b10, 32'hFFFF_F101, 32'h00000077, 3, 1'b0, 32'hA5EF_3344, 4'h2, 32'h77777777};
    tbl[13] = '{0, 1'b0, 2'b00, 32'h0000_0100, 32'h0,        3, 1'b0, 32'hA5EF_7744, 4'hF, 32'h0};
    tbl[14] = '{1, 1'b1, 2'b00, 32'h0000_0040, 32'hCAFEF00D, 6, 1'b0, 32'h0000_0000, 4'hF, 32'hCAFEF00D};
    tbl[15] = '{1, 1'b0, 2'b10, 32'h0000_0041, 32'h0,        6, 1'b0, 32'h0000_00F0, 4'h2, 32'h0};

    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b0; mreq[g] = 1'b0; write[g] = 1'b0; size[g] = 2'b00;
      dad[g] = '0; ddt_wr[g] = '0; mrd[g] = '0;
      for (int b = 0; b < 1024; b++) gm[g][b] = 8'(init_word(g, b / 4) >> (8 * (b % 4)));
    end

    repeat (3) @(negedge clk);
    check_reset_values(0);
    check_reset_values(1);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      xact(tbl[i].d, tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, ac, ord, oerr, obe, owd);
      chk($sformatf("tbl%0d_ack", i), ac, tbl[i].ack);
      chk($sformatf("tbl%0d_err", i), oerr, tbl[i].err);
      chk($sformatf("tbl%0d_rd", i), ord, tbl[i].rd);
      chk($sformatf("tbl%0d_be", i), obe, tbl[i].be);
      chk($sformatf("tbl%0d_swd", i), owd, tbl[i].swd);
    end

    spacing(1, 32'h0000_0040);
    spacing(0, 32'h0000_0100);

    abort(1, 3, 32'h0000_0040);
    xact(1, 1'b0, 2'b00, 32'h0000_0040, 32'h0, ac, ord, oerr, obe, owd);
    chk("post_abort_rd1", ord, 32'hCAFEF00D);
    abort(0, 1, 32'h0000_0100);
    xact(0, 1'b0, 2'b01, 32'h0000_0100, 32'h0, ac, ord, oerr, obe, owd);
    chk("post_abort_rd0", ord, 32'h0000_7744);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 80; k++) begin
        rsz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        rnb = (rsz == 2'b01) ? 2 : (rsz == 2'b10) ? 1 : 4;
        ra  = $urandom;
        if ($urandom_range(0, 3) != 0) ra[1:0] = ra[1:0] & 2'(~(rnb - 1));
        xact(d, 1'($urandom_range(0, 1)), rsz, ra, $urandom, ac, ord, oerr, obe, owd);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
